demux12_reg: RTL
================

DEMUX12_REG -- requirements
Module: demux12_reg

Interface
REQ-001 Parameter: width, default 5, data width of the input word and of both output channels.
REQ-002 Port: clk  input  1  single clock; every state change is on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  the upstream word is valid this cycle.
REQ-005 Port: in_data  input  width  the upstream word.
REQ-006 Port: sel  input  1  destination: 0 = channel 0, 1 = channel 1; sampled together with in_data.
REQ-007 Port: in_ready  output  1  the demux accepts the upstream word this cycle.
REQ-008 Port: out0_valid, out1_valid  output  1 each  the channel holds a word.
REQ-009 Port: out0_data, out1_data  output  width each  the channel's held word.
REQ-010 Port: out0_ready, out1_ready  input  1 each  the downstream consumer takes the channel's word.
REQ-011 Port (DEMUX12_STATS_EN only): cnt0, cnt1  output  8 each  words delivered per channel.

Function
REQ-012 Handshakes: a transfer occurs only on a cycle where valid and ready are both high.
- Upstream: in_valid & in_ready.
- Channel n: outn_valid & outn_ready.
REQ-013 Each channel is a one-entry holding slot with two states:
- EMPTY: outn_valid = 0.
- FULL: outn_valid = 1.
REQ-014 Slot transitions, per edge:
- EMPTY to FULL on a load.
- FULL to EMPTY on a drain with no load.
- FULL stays FULL on a simultaneous drain and load; the new word replaces the old word.
REQ-015 in_ready is combinational and reflects the slot selected by the current sel.
- in_ready = slot[sel] EMPTY, or (slot[sel] FULL and outn_ready high for that slot).
- in_ready does not depend on in_valid.
- in_ready does not depend on the non-selected slot.
REQ-016 An accepted word is loaded into slot[sel] only. The other slot's state and data are unchanged.
REQ-017 Latency: a word accepted at edge k appears on outn_valid/outn_data immediately after edge k. Throughput is one word per cycle per channel.
REQ-018 outn_data holds its value while outn_valid is high and the word is not drained. It is not altered by traffic to the other channel.
REQ-019 outn_data keeps its last value after a drain; consumers ignore it while outn_valid = 0.
REQ-020 No reordering within a channel. There is no ordering requirement between the two channels.
REQ-021 A FULL slot with outn_ready low back-pressures only upstream words addressed to it; words addressed to the other channel continue to flow.

Reset
REQ-022 With rst high at an edge:
- out0_valid and out1_valid go to 0.
- out0_data and out1_data go to 0.
- cnt0 and cnt1 go to 0.
- Any held word is discarded.
REQ-023 While rst is high, no word is accepted: in_ready = 0. A drain in a reset cycle is not counted.
REQ-024 Reset asserted mid-operation, with slots FULL and stalled, returns both slots to EMPTY at that edge.

Configuration
REQ-025 Macro DEMUX12_STATS_EN, when defined:
- Adds cnt0/cnt1.
- Each counter increments on a drain transfer of its channel.
- Each counter saturates at 8'hFF and never wraps.
REQ-026 Without DEMUX12_STATS_EN:
- The cnt ports and counters do not exist.
- All other behaviour is identical.

Structure
REQ-027 Shared package demux_pkg holds:
- DEMUX_WIDTH_DEF = 5.
- Channel identifiers CH0 = 1'b0 and CH1 = 1'b1.
- Slot state type {SLOT_EMPTY, SLOT_FULL}.
- Counter width constant = 8.
REQ-028 Sub-module demux_slot implements one holding slot: state, data register, load/drain logic, and an optional counter. demux12_reg instantiates it twice and generates in_ready and the per-slot load enables.

Verification (width = 5)
REQ-029 Reset then idle.
- Stimulus: rst high 2 cycles, then low.
- Required: out0_valid = out1_valid = 0, out0_data = out1_data = 5'b00000, in_ready = 1 with in_valid = 0.
REQ-030 Basic routing.
- Stimulus: in_data = 5'b00001, sel = 0, in_valid 1 cycle; outputs ready.
- Required: out0_valid = 1 and out0_data = 5'b00001 the next cycle; out1_valid stays 0.
- Stimulus: repeat with in_data = 5'b10110, sel = 1.
- Required: out1_data = 5'b10110 next cycle.
REQ-031 Back-pressure isolation.
- Stimulus: out0_ready = 0, channel 0 FULL with 5'b00011; offer sel = 0 with 5'b00100.
- Required: in_ready = 0, and out0_data stays 5'b00011.
- Stimulus: switch the offer to sel = 1 with 5'b00101.
- Required: in_ready = 1, and out1_data = 5'b00101 the next cycle.
REQ-032 Simultaneous drain and load.
- Stimulus: channel 1 FULL with 5'b01010, out1_ready = 1, accept 5'b01011 with sel = 1 in the same cycle.
- Required: out1_valid stays 1 and out1_data = 5'b01011 after the edge.
- Stimulus: back-to-back streaming of 8 words.
- Required: one word delivered per cycle, in order.
REQ-033 Reset mid-operation.
- Stimulus: both slots FULL and stalled; assert rst for 1 cycle.
- Required: both valids 0 after that edge; no stale word emerges once out0_ready = out1_ready = 1.
REQ-034 Counters (DEMUX12_STATS_EN).
- Stimulus: 300 channel-0 drains, and 3 channel-1 drains.
- Required: cnt0 = 8'hFF (saturated), cnt1 = 8'h03.
- Stimulus: a build without the macro.
- Required: it elaborates and passes REQ-029 to REQ-033 unchanged.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-2 demux: widths, channel ids and slot state.
package demux_pkg;

  localparam int DEMUX_WIDTH_DEF = 5;
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

  // Saturating increment so delivery statistics stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot of the demux; optional delivery counter under DEMUX12_STATS_EN.
module demux_slot
  import demux_pkg::*;
#(
  parameter int width = DEMUX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             out_ready,
`ifdef DEMUX12_STATS_EN
  output logic [CNT_W-1:0] cnt,
`endif
  output logic             out_valid,
  output logic [width-1:0] out_data
);

  slot_state_t      state_q, state_d;
  logic [width-1:0] data_q, data_d;
  logic             drain;

  assign drain = (state_q == SLOT_FULL) && out_ready;

  // A load wins over a drain, so a simultaneous drain+load keeps the slot FULL.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = load_data;
    end else if (drain) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = data_q;

`ifdef DEMUX12_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drain) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: rtl/demux12_reg.sv
// Registered 1-to-2 demux with per-channel one-entry slots and independent back-pressure.
// Optional per-channel delivery counters (cnt0/cnt1) when DEMUX12_STATS_EN is defined.
module demux12_reg
  import demux_pkg::*;
#(
  parameter int width = DEMUX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  input  logic             sel,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [width-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [width-1:0] out1_data,
`ifdef DEMUX12_STATS_EN
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
`endif
  input  logic             out1_ready
);

  logic [1:0]       slot_valid;
  logic [1:0]       slot_ready;
  logic [1:0]       slot_load;
  logic [1:0]       ch_ready;
  logic [width-1:0] slot_data [2];
`ifdef DEMUX12_STATS_EN
  logic [CNT_W-1:0] slot_cnt [2];
`endif

  assign ch_ready = {out1_ready, out0_ready};

  // Only the selected slot decides in_ready; the other channel never stalls this word.
  assign in_ready = !rst && ((sel == CH1) ? slot_ready[1] : slot_ready[0]);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      assign slot_ready[gi] = !slot_valid[gi] || ch_ready[gi];
      assign slot_load[gi]  = in_valid && in_ready && (sel == 1'(gi));

      demux_slot #(.width(width)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (slot_load[gi]),
        .load_data (in_data),
        .out_ready (ch_ready[gi]),
`ifdef DEMUX12_STATS_EN
        .cnt       (slot_cnt[gi]),
`endif
        .out_valid (slot_valid[gi]),
        .out_data  (slot_data[gi])
      );
    end
  endgenerate

  assign out0_valid = slot_valid[0];
  assign out1_valid = slot_valid[1];
  assign out0_data  = slot_data[0];
  assign out1_data  = slot_data[1];
`ifdef DEMUX12_STATS_EN
  assign cnt0 = slot_cnt[0];
  assign cnt1 = slot_cnt[1];
`endif

endmodule
